// File: rtl/note_judge.sv
`default_nettype none
// ============================================================================
//  Module   : note_judge
//  Purpose  : Rhythm-game note judge. Synchronizes raw fret/strum buttons,
//             opens a judging window two cycles after every chart beat,
//             grades strums against the latched note pattern and keeps
//             score, streak and multiplier.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50   in   1   system clock, rising-edge
//    resetn     in   1   asynchronous active-low reset
//    beat       in   1   single-cycle eighth-note pulse from the sequencer
//    exp_notes  in   5   expected fret pattern, 0 = no note
//    frets_n    in   5   raw fret buttons, active-low, asynchronous
//    strum_n    in   1   raw strum button, active-low, asynchronous
//    pause      in   1   high freezes all judging state
//    score      out 16   accumulated score (saturating)
//    streak     out  8   consecutive hits (saturating at MAX_STREAK)
//    mult       out  3   multiplier 1..4 derived from streak
//    hit        out  1   single-cycle pulse, correct strum
//    miss       out  1   single-cycle pulse, wrong strum/unplayed/overstrum
// ============================================================================
module note_judge #(
    parameter int HIT_POINTS = 10,
    parameter int MAX_STREAK = 255
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        beat,
    input  logic [4:0]  exp_notes,
    input  logic [4:0]  frets_n,
    input  logic        strum_n,
    input  logic        pause,
    output logic [15:0] score,
    output logic [7:0]  streak,
    output logic [2:0]  mult,
    output logic        hit,
    output logic        miss
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_ARMED    = 2'd1;
    localparam logic [1:0]  ST_JUDGED   = 2'd2;

    localparam logic [7:0]  C_MAX_STREAK = 8'(MAX_STREAK);
    localparam logic [16:0] C_HIT_PTS    = 17'(HIT_POINTS);
    localparam logic [16:0] C_SCORE_MAX  = 17'h0_FFFF;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [4:0] frets_s1_q;
    logic [4:0] frets_s2_q;
    logic       strum_s1_q;
    logic       strum_s2_q;
    logic       strum_q;        // registered synchronized strum level
    logic       strum_prev_q;   // strum_q one cycle earlier

    logic [4:0] frets;          // active-high fret pattern
    logic       strum_evt;

    // Button flops reset to 1 so a released button never looks pressed
    // coming out of reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            frets_s1_q   <= 5'h1F;
            frets_s2_q   <= 5'h1F;
            strum_s1_q   <= 1'b1;
            strum_s2_q   <= 1'b1;
            strum_q      <= 1'b1;
            strum_prev_q <= 1'b1;
        end else begin
            frets_s1_q   <= frets_n;
            frets_s2_q   <= frets_s1_q;
            strum_s1_q   <= strum_n;
            strum_s2_q   <= strum_s1_q;
            strum_q      <= strum_s2_q;
            strum_prev_q <= strum_q;
        end
    end

    assign frets     = ~frets_s2_q;
    // Falling edge of the synchronized strum: press, not hold. These flops
    // keep running through pause, so a button held across un-pause has
    // already been absorbed and produces no event.
    assign strum_evt = ~strum_q & strum_prev_q;

    // ------------------------------------------------------------------
    // Beat delay line -> judging window
    // ------------------------------------------------------------------
    logic beat_d1_q;
    logic beat_d2_q;
    logic win_open;

    // Beats seen while paused are dropped at the entry of the delay line
    // so they can never open a window after un-pause.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            beat_d1_q <= 1'b0;
            beat_d2_q <= 1'b0;
        end else begin
            beat_d1_q <= beat & ~pause;
            beat_d2_q <= beat_d1_q & ~pause;
        end
    end

    assign win_open = beat_d2_q;

    // ------------------------------------------------------------------
    // Multiplier from streak
    // ------------------------------------------------------------------
    function automatic logic [2:0] f_mult(input logic [7:0] s);
        if (s < 8'd10)      f_mult = 3'd1;
        else if (s < 8'd20) f_mult = 3'd2;
        else if (s < 8'd30) f_mult = 3'd3;
        else                f_mult = 3'd4;
    endfunction

    // ------------------------------------------------------------------
    // Judging state
    // ------------------------------------------------------------------
    logic [1:0]  state_q,  state_d;
    logic [4:0]  note_q,   note_d;
    logic [7:0]  streak_q, streak_d;
    logic [15:0] score_q,  score_d;
    logic        hit_q,    hit_d;
    logic        miss_q,   miss_d;

    // Intermediate view of the state after the window step, so a strum in
    // the same cycle as win_open is judged against the newly armed note.
    logic [1:0]  cur_state;
    logic [4:0]  cur_note;
    logic [7:0]  cur_streak;
    logic [2:0]  cur_mult;
    logic [16:0] points;
    logic [16:0] sum;

    always_comb begin
        state_d    = state_q;
        note_d     = note_q;
        streak_d   = streak_q;
        score_d    = score_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        cur_state  = state_q;
        cur_note   = note_q;
        cur_streak = streak_q;
        cur_mult   = 3'd1;
        points     = 17'd0;
        sum        = 17'd0;

        if (!pause) begin
            // Window step: an armed note that was never played is a miss,
            // then the new pattern is latched.
            if (win_open) begin
                if (state_q == ST_ARMED) begin
                    miss_d     = 1'b1;
                    cur_streak = 8'd0;
                end
                cur_note  = exp_notes;
                cur_state = (exp_notes != 5'd0) ? ST_ARMED : ST_IDLE;
            end

            // Strum step, judged against the post-window view.
            if (strum_evt) begin
                case (cur_state)
                    ST_ARMED: begin
                        if (frets == cur_note) begin
                            hit_d    = 1'b1;
                            // Multiplier in force before this hit counts.
                            cur_mult = f_mult(cur_streak);
                            points   = C_HIT_PTS * {14'd0, cur_mult};
                            sum      = {1'b0, score_q} + points;
                            score_d  = (sum > C_SCORE_MAX) ? 16'hFFFF : sum[15:0];
                            if (cur_streak < C_MAX_STREAK) begin
                                cur_streak = cur_streak + 8'd1;
                            end
                        end else begin
                            miss_d     = 1'b1;
                            cur_streak = 8'd0;
                        end
                        cur_state = ST_JUDGED;
                    end
                    ST_IDLE: begin
                        // Overstrum: nothing to play.
                        miss_d     = 1'b1;
                        cur_streak = 8'd0;
                    end
                    default: begin
                        // Already judged this window: ignore.
                    end
                endcase
            end

            state_d  = cur_state;
            note_d   = cur_note;
            streak_d = cur_streak;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            note_q   <= 5'd0;
            streak_q <= 8'd0;
            score_q  <= 16'd0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            streak_q <= streak_d;
            score_q  <= score_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign score  = score_q;
    assign streak = streak_q;
    assign mult   = f_mult(streak_q);
    assign hit    = hit_q;
    assign miss   = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_note_judge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note_judge
//  Purpose  : Directed self-checking bench for note_judge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_note_judge;

    logic        clk;
    logic        resetn;
    logic        beat;
    logic [4:0]  exp_notes;
    logic [4:0]  frets_n;
    logic        strum_n;
    logic        pause;
    logic [15:0] score;
    logic [7:0]  streak;
    logic [2:0]  mult;
    logic        hit;
    logic        miss;

    int vectors;
    int miscompares;

    note_judge #(
        .HIT_POINTS(10),
        .MAX_STREAK(255)
    ) u_dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .beat     (beat),
        .exp_notes(exp_notes),
        .frets_n  (frets_n),
        .strum_n  (strum_n),
        .pause    (pause),
        .score    (score),
        .streak   (streak),
        .mult     (mult),
        .hit      (hit),
        .miss     (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking) ----------------
    // Pulse beat; return the pulses seen once the window has been processed.
    task automatic do_beat(input logic [4:0] notes, output logic h, output logic m);
        exp_notes = notes;
        beat      = 1'b1;
        @(negedge clk);
        beat = 1'b0;
        @(negedge clk);
        @(negedge clk);
        h = hit;
        m = miss;
    endtask

    // Press strum with a fret pattern; 'early' collects any pulse outside
    // the expected result cycle (3 cycles after the first sampling edge).
    task automatic do_strum(input logic [4:0] f, output logic early,
                            output logic h, output logic m);
        early   = 1'b0;
        frets_n = f;
        strum_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            early = early | hit | miss;
        end
        @(negedge clk);
        h = hit;
        m = miss;
        strum_n = 1'b1;
        @(negedge clk);
        early = early | hit | miss;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (score !== 16'd0) begin miscompares++; $display("FAIL reset_score got %0d want 0", score); end
        vectors++; if (streak !== 8'd0) begin miscompares++; $display("FAIL reset_streak got %0d want 0", streak); end
        vectors++; if (mult !== 3'd1) begin miscompares++; $display("FAIL reset_mult got %0d want 1", mult); end
        vectors++; if ({hit, miss} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses got %b want 00", {hit, miss}); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hit();
        logic h, m, e;
        do_beat(5'b00101, h, m);
        vectors++; if ({h, m} !== 2'b00) begin miscompares++; $display("FAIL hit_arm pulses got %b want 00", {h, m}); end
        do_strum(5'b11010, e, h, m);
        vectors++; if ({e, h, m} !== 3'b010) begin miscompares++; $display("FAIL hit_strum early/hit/miss got %b want 010", {e, h, m}); end
        vectors++; if (score !== 16'd10) begin miscompares++; $display("FAIL hit_score got %0d want 10", score); end
        vectors++; if (streak !== 8'd1 || mult !== 3'd1) begin miscompares++; $display("FAIL hit_streak_mult got %0d/%0d want 1/1", streak, mult); end
    endtask

    task automatic test_unplayed();
        logic h, m;
        do_beat(5'b00101, h, m);
        vectors++; if ({h, m} !== 2'b00) begin miscompares++; $display("FAIL unplayed_arm got %b want 00", {h, m}); end
        do_beat(5'b00101, h, m);
        vectors++; if ({h, m} !== 2'b01) begin miscompares++; $display("FAIL unplayed_miss got %b want 01", {h, m}); end
        vectors++; if (streak !== 8'd0 || score !== 16'd10) begin miscompares++; $display("FAIL unplayed_state got streak %0d score %0d want 0 10", streak, score); end
    endtask

    // Strum event lands on the same cycle as win_open while ARMED.
    task automatic test_same_cycle();
        frets_n = 5'b11010;
        strum_n = 1'b0;
        @(negedge clk);
        exp_notes = 5'b00101;
        beat      = 1'b1;
        @(negedge clk);
        beat = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if ({hit, miss} !== 2'b11) begin miscompares++; $display("FAIL same_cycle pulses got %b want 11", {hit, miss}); end
        strum_n = 1'b1;
        repeat (4) @(negedge clk);
        vectors++; if (score !== 16'd20 || streak !== 8'd1 || mult !== 3'd1) begin
            miscompares++; $display("FAIL same_cycle_state got %0d/%0d/%0d want 20/1/1", score, streak, mult);
        end
    endtask

    task automatic test_wrong_frets();
        logic h, m, e;
        do_beat(5'b00011, h, m);
        do_strum(5'b11110, e, h, m);
        vectors++; if ({e, h, m} !== 3'b001) begin miscompares++; $display("FAIL wrong_frets got %b want 001", {e, h, m}); end
        vectors++; if (streak !== 8'd0 || score !== 16'd20) begin miscompares++; $display("FAIL wrong_frets_state got %0d/%0d want 0/20", streak, score); end
    endtask

    task automatic test_overstrum_judged();
        logic h, m, e;
        do_beat(5'b00000, h, m);
        do_strum(5'b11111, e, h, m);
        vectors++; if ({e, h, m} !== 3'b001) begin miscompares++; $display("FAIL overstrum got %b want 001", {e, h, m}); end
        do_beat(5'b00101, h, m);
        vectors++; if ({h, m} !== 2'b00) begin miscompares++; $display("FAIL idle_to_armed got %b want 00", {h, m}); end
        do_strum(5'b11010, e, h, m);
        vectors++; if ({e, h, m} !== 3'b010 || score !== 16'd30) begin miscompares++; $display("FAIL judged_first got %b score %0d want 010 30", {e, h, m}, score); end
        do_strum(5'b11010, e, h, m);
        vectors++; if ({e, h, m} !== 3'b000) begin miscompares++; $display("FAIL judged_ignore got %b want 000", {e, h, m}); end
        vectors++; if (score !== 16'd30 || streak !== 8'd1) begin miscompares++; $display("FAIL judged_hold got %0d/%0d want 30/1", score, streak); end
    endtask

    task automatic test_streak_mult();
        logic h, m, e;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            do_beat(5'b00101, h, m);
            do_strum(5'b11010, e, h, m);
            vectors++; if ({e, h, m} !== 3'b010) begin miscompares++; $display("FAIL streak_hit%0d got %b want 010", i, {e, h, m}); end
            vectors++;
            if (score !== ((i <= 10) ? 16'(10 * i) : 16'd120)) begin
                miscompares++; $display("FAIL streak_score%0d got %0d want %0d", i, score, (i <= 10) ? 10 * i : 120);
            end
            if (i == 9 || i == 10) begin
                vectors++;
                if (mult !== ((i == 9) ? 3'd1 : 3'd2)) begin
                    miscompares++; $display("FAIL streak_mult%0d got %0d want %0d", i, mult, (i == 9) ? 1 : 2);
                end
            end
        end
        vectors++; if (streak !== 8'd11 || mult !== 3'd2) begin miscompares++; $display("FAIL streak_final got %0d/%0d want 11/2", streak, mult); end
    endtask

    task automatic test_pause();
        logic h, m, e, any;
        do_beat(5'b00101, h, m);    // ARMED
        pause     = 1'b1;
        exp_notes = 5'b00101;
        beat      = 1'b1;
        @(negedge clk);
        beat    = 1'b0;
        frets_n = 5'b11010;
        strum_n = 1'b0;
        any = 1'b0;
        repeat (8) begin @(negedge clk); any = any | hit | miss; end
        vectors++; if (any !== 1'b0) begin miscompares++; $display("FAIL pause_pulses got %b want 0", any); end
        vectors++; if (score !== 16'd120 || streak !== 8'd11) begin miscompares++; $display("FAIL pause_hold got %0d/%0d want 120/11", score, streak); end
        pause = 1'b0;               // strum still held
        any = 1'b0;
        repeat (8) begin @(negedge clk); any = any | hit | miss; end
        vectors++; if (any !== 1'b0) begin miscompares++; $display("FAIL unpause_pulses got %b want 0", any); end
        strum_n = 1'b1;
        repeat (4) @(negedge clk);
        do_strum(5'b11010, e, h, m);
        vectors++; if ({e, h, m} !== 3'b010) begin miscompares++; $display("FAIL after_pause_hit got %b want 010", {e, h, m}); end
        vectors++; if (score !== 16'd140 || streak !== 8'd12) begin miscompares++; $display("FAIL after_pause_state got %0d/%0d want 140/12", score, streak); end
    endtask

    task automatic test_reset_mid();
        logic h, m, any;
        do_beat(5'b00101, h, m);    // ARMED
        resetn = 1'b0;
        @(negedge clk);
        vectors++; if (score !== 16'd0 || streak !== 8'd0 || mult !== 3'd1) begin
            miscompares++; $display("FAIL midreset_state got %0d/%0d/%0d want 0/0/1", score, streak, mult);
        end
        resetn = 1'b1;
        any = 1'b0;
        repeat (4) begin @(negedge clk); any = any | hit | miss; end
        vectors++; if (any !== 1'b0) begin miscompares++; $display("FAIL midreset_pulse got %b want 0", any); end
        do_beat(5'b00101, h, m);
        vectors++; if ({h, m} !== 2'b00) begin miscompares++; $display("FAIL midreset_idle got %b want 00", {h, m}); end
    endtask

    // Hit until the score clamps, then two more hits (FSM starts ARMED).
    task automatic test_saturate();
        logic h, m, e;
        int   exp_score, exp_streak, exp_m, after;
        exp_score  = 0;
        exp_streak = 0;
        after      = 0;
        for (int n = 0; n < 3000 && after < 2; n++) begin
            if (exp_score == 65535) after++;
            exp_m      = (exp_streak < 10) ? 1 : (exp_streak < 20) ? 2 : (exp_streak < 30) ? 3 : 4;
            exp_score  = (exp_score + 10 * exp_m > 65535) ? 65535 : exp_score + 10 * exp_m;
            exp_streak = (exp_streak < 255) ? exp_streak + 1 : 255;
            do_strum(5'b11010, e, h, m);
            vectors++;
            if ({e, h, m} !== 3'b010 || score !== 16'(exp_score)) begin
                miscompares++; $display("FAIL sat_hit%0d got %b score %0d want 010 %0d", n, {e, h, m}, score, exp_score);
            end
            do_beat(5'b00101, h, m);
        end
        vectors++; if (after !== 2) begin miscompares++; $display("FAIL sat_reached got %0d want 2", after); end
        vectors++; if (score !== 16'hFFFF) begin miscompares++; $display("FAIL sat_score got %0d want 65535", score); end
        vectors++; if (streak !== 8'd255 || mult !== 3'd4) begin miscompares++; $display("FAIL sat_streak got %0d/%0d want 255/4", streak, mult); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        beat        = 1'b0;
        exp_notes   = 5'd0;
        frets_n     = 5'h1F;
        strum_n     = 1'b1;
        pause       = 1'b0;
        @(negedge clk);
        test_reset();
        test_hit();
        test_unplayed();
        test_same_cycle();
        test_wrong_frets();
        test_overstrum_judged();
        test_streak_mult();
        test_pause();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
